r5p_degu_rst_ctl: RTL and testbench

Reset and button controller for the degu SoC on Gowin boards.
- Synchronizes and debounces the raw active-low board buttons.
- Waits for PLL lock, then stretches and synchronously releases the active-high SoC reset.
- Re-enters reset on a debounced reset-button press or on PLL lock loss.
- Sits between the board pins/PLL and r5p_degu_soc_top's clk/rst.

---
 rtl/r5p_degu_rst_ctl.sv | 188 ++++++++++++++++++
 tb/tb_r5p_degu_rst_ctl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r5p_degu_rst_ctl.sv
// Reset and button controller for the degu SoC: synchronizes/debounces buttons, waits for PLL lock
// and stretches the SoC reset. Optional watchdog restart enabled by macro R5P_DEGU_RST_WDT_EN.
module r5p_degu_rst_ctl #(
  parameter int unsigned BTN_NUM = 2,
  parameter int unsigned RST_BTN = 0,
  parameter int unsigned SYNC_FF = 2,
  parameter int unsigned DEB_CNT = 2**18,
  parameter int unsigned RST_CNT = 16
`ifdef R5P_DEGU_RST_WDT_EN
 ,parameter int unsigned WDT_CNT = 2**24
`endif
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic [BTN_NUM-1:0] btn_n,
  output logic [BTN_NUM-1:0] btn_o,
  output logic [BTN_NUM-1:0] btn_p,
  output logic               soc_rst,
  output logic [1:0]         state_o
`ifdef R5P_DEGU_RST_WDT_EN
 ,input  logic               wdt_kick,
  output logic               wdt_flag
`endif
);

  localparam int unsigned DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int unsigned RW = (RST_CNT > 1) ? $clog2(RST_CNT) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT - 1);
  localparam logic [RW-1:0] RST_MAX = RW'(RST_CNT - 1);

  typedef enum logic [1:0] {
    ST_RST     = 2'd0,
    ST_LOCK    = 2'd1,
    ST_STRETCH = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [SYNC_FF-1:0]              lockSync_q;
  logic [SYNC_FF-1:0][BTN_NUM-1:0] btnSync_q;
  logic                            lockS;
  logic [BTN_NUM-1:0]              btnS;

  logic [BTN_NUM-1:0][DW-1:0] debCnt_q, debCnt_d;
  logic [BTN_NUM-1:0]         btnO_q, btnO_d, btnP_q, btnP_d;

  state_t          state_q, state_d;
  logic [RW-1:0]   rstCnt_q, rstCnt_d;
  logic            socRst_q;

  // Buttons idle released (1) and lock idles lost (0) while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockSync_q <= '0;
      btnSync_q  <= '1;
    end else begin
      lockSync_q <= {lockSync_q[SYNC_FF-2:0], pll_lock};
      btnSync_q  <= {btnSync_q[SYNC_FF-2:0], btn_n};
    end
  end

  assign lockS = lockSync_q[SYNC_FF-1];
  assign btnS  = btnSync_q[SYNC_FF-1];

  // btnS is active-low, so equality with btnO_q means the sample disagrees with the debounced level.
  always_comb begin
    debCnt_d = '0;
    btnO_d   = btnO_q;
    for (int i = 0; i < BTN_NUM; i++) begin
      if (btnS[i] == btnO_q[i]) begin
        if (debCnt_q[i] == DEB_MAX) begin
          btnO_d[i] = ~btnO_q[i];
        end else begin
          debCnt_d[i] = debCnt_q[i] + 1'b1;
        end
      end
    end
    btnP_d = btnO_d & ~btnO_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debCnt_q <= '0;
      btnO_q   <= '0;
      btnP_q   <= '0;
    end else begin
      debCnt_q <= debCnt_d;
      btnO_q   <= btnO_d;
      btnP_q   <= btnP_d;
    end
  end

`ifdef R5P_DEGU_RST_WDT_EN
  localparam int unsigned WW = (WDT_CNT > 1) ? $clog2(WDT_CNT) : 1;
  localparam logic [WW-1:0] WDT_MAX = WW'(WDT_CNT - 1);

  logic [WW-1:0] wdtCnt_q, wdtCnt_d;
  logic          wdtFire;
  logic          wdtFlag_q;

  always_comb begin
    wdtCnt_d = '0;
    if ((state_q == ST_RUN) && !wdt_kick && (wdtCnt_q != WDT_MAX)) begin
      wdtCnt_d = wdtCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdtCnt_q  <= '0;
      wdtFlag_q <= 1'b0;
    end else begin
      wdtCnt_q  <= wdtCnt_d;
      wdtFlag_q <= wdtFlag_q | wdtFire;
    end
  end

  assign wdt_flag = wdtFlag_q;
`endif

  // Lock loss outranks the reset button, which outranks the watchdog.
  always_comb begin
    state_d  = state_q;
    rstCnt_d = rstCnt_q;
`ifdef R5P_DEGU_RST_WDT_EN
    wdtFire  = 1'b0;
`endif
    case (state_q)
      ST_RST: begin
        state_d = ST_LOCK;
      end
      ST_LOCK: begin
        if (lockS) begin
          state_d  = ST_STRETCH;
          rstCnt_d = '0;
        end
      end
      ST_STRETCH: begin
        if (!lockS) begin
          state_d = ST_LOCK;
        end else if (btnO_q[RST_BTN]) begin
          rstCnt_d = '0;
        end else if (rstCnt_q == RST_MAX) begin
          state_d = ST_RUN;
        end else begin
          rstCnt_d = rstCnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lockS) begin
          state_d = ST_LOCK;
        end else if (btnP_q[RST_BTN] || btnO_q[RST_BTN]) begin
          state_d  = ST_STRETCH;
          rstCnt_d = '0;
        end
`ifdef R5P_DEGU_RST_WDT_EN
        else if (!wdt_kick && (wdtCnt_q == WDT_MAX)) begin
          state_d  = ST_STRETCH;
          rstCnt_d = '0;
          wdtFire  = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // soc_rst is registered from the next state so it switches on the same edge as state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RST;
      rstCnt_q <= '0;
      socRst_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      rstCnt_q <= rstCnt_d;
      socRst_q <= (state_d != ST_RUN);
    end
  end

  assign btn_o   = btnO_q;
  assign btn_p   = btnP_q;
  assign soc_rst = socRst_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_r5p_degu_rst_ctl.sv
// Bench for r5p_degu_rst_ctl: directed test-plan steps plus randomized button/lock stimulus,
// checked every cycle against a countdown-based behavioural model.
module tb_r5p_degu_rst_ctl;

  localparam int BTN_NUM = 2;
  localparam int RST_BTN = 0;
  localparam int SYNC_FF = 2;
  localparam int DEB_CNT = 4;
  localparam int RST_CNT = 4;
  localparam int WDT_CNT = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pll_lock;
  logic [BTN_NUM-1:0] btn_n;
  logic [BTN_NUM-1:0] btn_o;
  logic [BTN_NUM-1:0] btn_p;
  logic               soc_rst;
  logic [1:0]         state_o;
  logic               wdt_kick;
`ifdef R5P_DEGU_RST_WDT_EN
  logic               wdt_flag;
`endif

  r5p_degu_rst_ctl #(
    .BTN_NUM (BTN_NUM),
    .RST_BTN (RST_BTN),
    .SYNC_FF (SYNC_FF),
    .DEB_CNT (DEB_CNT),
    .RST_CNT (RST_CNT)
`ifdef R5P_DEGU_RST_WDT_EN
   ,.WDT_CNT (WDT_CNT)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .btn_n    (btn_n),
    .btn_o    (btn_o),
    .btn_p    (btn_p),
    .soc_rst  (soc_rst),
    .state_o  (state_o)
`ifdef R5P_DEGU_RST_WDT_EN
   ,.wdt_kick (wdt_kick),
    .wdt_flag (wdt_flag)
`endif
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int failCnt = 0;
  int checkCnt = 0;

  // Reference model: phase number (0 reset, 1 waiting lock, 2 stretching, 3 running),
  // cycles of reset left to serve, and delay lines for the synchronized inputs.
  int         mSt;
  int         mLeft;
  int         mIdle;
  int         mRun [BTN_NUM];
  logic       mFlag;
  logic       mSocRst;
  logic [1:0] mBtnO;
  logic [1:0] mBtnP;
  logic       mLockQ [$];
  logic [1:0] mBtnQ  [$];

  task automatic modelReset();
    mSt = 0; mLeft = 0; mIdle = 0; mFlag = 1'b0; mSocRst = 1'b1;
    mBtnO = '0; mBtnP = '0;
    for (int i = 0; i < BTN_NUM; i++) mRun[i] = 0;
    mLockQ.delete();
    mBtnQ.delete();
    for (int i = 0; i < SYNC_FF; i++) begin
      mLockQ.push_back(1'b0);
      mBtnQ.push_back(2'b11);
    end
  endtask

  task automatic modelStep(input logic lockIn, input logic [1:0] btnIn, input logic kickIn);
    logic       lockS;
    logic [1:0] btnS, oldO, newO;
    int         nSt;
    lockS = mLockQ[0];
    btnS  = mBtnQ[0];
    oldO  = mBtnO;
    newO  = mBtnO;
    nSt   = mSt;
    for (int i = 0; i < BTN_NUM; i++) begin
      if ((!btnS[i]) != oldO[i]) begin
        mRun[i]++;
        if (mRun[i] == DEB_CNT) begin
          newO[i] = ~oldO[i];
          mRun[i] = 0;
        end
      end else begin
        mRun[i] = 0;
      end
    end
    case (mSt)
      0: nSt = 1;
      1: if (lockS) begin nSt = 2; mLeft = RST_CNT; end
      2: begin
        if (!lockS) nSt = 1;
        else if (oldO[RST_BTN]) mLeft = RST_CNT;
        else begin
          mLeft--;
          if (mLeft == 0) nSt = 3;
        end
      end
      default: begin
        if (!lockS) nSt = 1;
        else if (mBtnP[RST_BTN] || oldO[RST_BTN]) begin nSt = 2; mLeft = RST_CNT; end
        else begin
`ifdef R5P_DEGU_RST_WDT_EN
          if (kickIn) mIdle = 0;
          else begin
            mIdle++;
            if (mIdle == WDT_CNT) begin nSt = 2; mLeft = RST_CNT; mFlag = 1'b1; end
          end
`endif
        end
      end
    endcase
    if (nSt != 3) mIdle = 0;
    mBtnP   = newO & ~oldO;
    mBtnO   = newO;
    mSt     = nSt;
    mSocRst = (nSt != 3);
    mLockQ.push_back(lockIn);
    void'(mLockQ.pop_front());
    mBtnQ.push_back(btnIn);
    void'(mBtnQ.pop_front());
    if (kickIn === 1'bx) $display("[TB] kick undefined");
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("soc_rst", 32'(soc_rst), 32'(mSocRst));
    checkOutput("state_o", 32'(state_o), 32'(mSt));
    checkOutput("btn_o",   32'(btn_o),   32'(mBtnO));
    checkOutput("btn_p",   32'(btn_p),   32'(mBtnP));
`ifdef R5P_DEGU_RST_WDT_EN
    checkOutput("wdt_flag", 32'(wdt_flag), 32'(mFlag));
`endif
  endtask

  // One clock edge: inputs seen by the edge feed the model, outputs compared 1 ns later.
  task automatic tick();
    logic       lockIn, kickIn;
    logic [1:0] btnIn;
    lockIn = pll_lock;
    btnIn  = btn_n;
    kickIn = wdt_kick;
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(lockIn, btnIn, kickIn);
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic lock, input logic [1:0] btn, input logic kick, input int n);
    pll_lock = lock;
    btn_n    = btn;
    wdt_kick = kick;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic assertReset(input int cycles);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic countToRun(input string tag);
    int n;
    n = 0;
    while (soc_rst !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(n), 32'(SYNC_FF + 1 + RST_CNT));
  endtask

  initial begin
    int n;
    rst_n = 1'b1; pll_lock = 1'b1; btn_n = 2'b11; wdt_kick = 1'b1;
    @(posedge clk); #1;

    // Power-on with lock stable
    assertReset(3);
    countToRun("por_edges");
    applyStimulus(1'b1, 2'b11, 1'b1, 3);

    // Debounce: short glitch then a long press on the non-reset button, then on the reset button
    applyStimulus(1'b1, 2'b01, 1'b1, 3);
    applyStimulus(1'b1, 2'b11, 1'b1, 8);
    applyStimulus(1'b1, 2'b01, 1'b1, 10);
    applyStimulus(1'b1, 2'b11, 1'b1, 8);
    applyStimulus(1'b1, 2'b10, 1'b1, 3);
    applyStimulus(1'b1, 2'b11, 1'b1, 8);

    // Reset button held
    applyStimulus(1'b1, 2'b10, 1'b1, 20);
    applyStimulus(1'b1, 2'b11, 1'b1, 14);

    // Lock loss, then lock loss coinciding with a debounced reset press
    applyStimulus(1'b0, 2'b11, 1'b1, 5);
    applyStimulus(1'b1, 2'b11, 1'b1, 12);
    applyStimulus(1'b1, 2'b10, 1'b1, 4);
    applyStimulus(1'b0, 2'b10, 1'b1, 5);
    applyStimulus(1'b1, 2'b10, 1'b1, 2);
    applyStimulus(1'b1, 2'b11, 1'b1, 16);

    // Mid-operation reset during stretch with two cycles served
    applyStimulus(1'b0, 2'b11, 1'b1, 3);
    pll_lock = 1'b1;
    n = 0;
    while (!(mSt == 2 && mLeft == RST_CNT - 2) && n < 30) begin
      tick();
      n++;
    end
    checkOutput("stretch_reached", 32'(n < 30), 32'(1));
    #3;
    assertReset(1);
    countToRun("por_again_edges");
    applyStimulus(1'b1, 2'b11, 1'b1, 3);

`ifdef R5P_DEGU_RST_WDT_EN
    // Watchdog: regular kicks keep RUN, silence triggers a sticky restart
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'b11, 1'b1, 1);
      applyStimulus(1'b1, 2'b11, 1'b0, 5);
    end
    applyStimulus(1'b1, 2'b11, 1'b0, 12);
    applyStimulus(1'b1, 2'b11, 1'b1, 10);
    checkOutput("wdt_flag_sticky", 32'(wdt_flag), 32'(1));
    assertReset(2);
    applyStimulus(1'b1, 2'b11, 1'b1, 10);
`endif

    // Randomized buttons, lock drops and kicks
    for (int k = 0; k < 60; k++) begin
      applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 12));
      if ($urandom_range(0, 15) == 0) begin
        #2;
        assertReset($urandom_range(0, 2));
      end
    end
    applyStimulus(1'b1, 2'b11, 1'b1, 10);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
